// File: rtl/vector_cmd_parser_pkg.sv
// vector_cmd_pkg
//   Shared constants and types for the UART vector-command parser:
//   opcode encodings, coordinate/command widths, header-bit position,
//   FSM state encodings and the packed FIFO command word.
package vector_cmd_pkg;

   localparam int unsigned COORD_W = 12;
   localparam int unsigned CMD_W   = 25;
   localparam int unsigned HDR_BIT = 7;

   localparam logic [1:0] OP_JUMP = 2'b00;
   localparam logic [1:0] OP_DRAW = 2'b01;

   typedef enum logic [1:0] {
      ASM_HDR,
      ASM_D1,
      ASM_D2,
      ASM_D3
   } asm_state_e;

   typedef enum logic {
      ISS_IDLE,
      ISS_GAP
   } iss_state_e;

   // One queued command: {op[0], x, y}, 25 bits.
   typedef struct packed {
      logic               is_draw;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } cmd_t;

endpackage

// File: rtl/vector_cmd_parser_fifo.sv
// cmd_fifo
//   Synchronous single-clock FIFO with combinational head read.
//   Ports: clk, reset_n (async, active-low), push/din write side,
//   pop/dout read side, empty/full flags, level = entry count.
//   A push while full is accepted only if a pop happens in the same cycle;
//   a pop while empty is ignored. DEPTH must be a power of two, >= 2.
module cmd_fifo #(
   parameter int unsigned WIDTH = 25,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_push, do_pop;

   assign empty = (level_q == '0);
   assign full  = (level_q == LVL_W'(DEPTH));
   assign level = level_q;
   assign dout  = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: contents are only observed behind a valid level.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/vector_cmd_parser.sv
// vector_cmd_parser
//   Assembles 4-byte UART vector packets into JUMP/DRAW commands, queues
//   them, and issues one command at a time to the line-draw control stage.
//   Ports:
//     clk, reset_n        clock, async active-low reset
//     rx_data, rx_valid   received UART byte and its one-cycle strobe
//     ready               control stage can accept a command
//     x, y                target coordinate, held between commands
//     draw, jump          one-cycle command pulses (mutually exclusive)
//     fifo_level          number of queued commands
//     frame_err           one-cycle pulse on framing or reserved-opcode error
//     overflow            one-cycle pulse when a complete packet is dropped
module vector_cmd_parser
   import vector_cmd_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [7:0]                    rx_data,
   input  logic                          rx_valid,
   input  logic                          ready,
   output logic [COORD_W-1:0]            x,
   output logic [COORD_W-1:0]            y,
   output logic                          draw,
   output logic                          jump,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          frame_err,
   output logic                          overflow
);

   asm_state_e         asm_q, asm_d;
   iss_state_e         iss_q, iss_d;
   logic [1:0]         op_q, op_d;
   logic [COORD_W-1:0] xa_q, xa_d;
   logic [6:0]         yhi_q, yhi_d;
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic               draw_q, draw_d;
   logic               jump_q, jump_d;
   logic               frame_err_q, frame_err_d;
   logic               overflow_q, overflow_d;

   logic               is_hdr;
   logic               pkt_done;
   logic               pop;
   cmd_t               push_cmd;
   cmd_t               head;
   logic [CMD_W-1:0]   fifo_dout;
   logic               fifo_empty;
   logic               fifo_full;

   assign is_hdr = rx_data[HDR_BIT];

   // Packet assembler: a header byte always restarts a packet, so a lost
   // data byte costs only the packet in flight.
   always_comb begin
      asm_d       = asm_q;
      op_d        = op_q;
      xa_d        = xa_q;
      yhi_d       = yhi_q;
      frame_err_d = 1'b0;
      pkt_done    = 1'b0;
      if (rx_valid) begin
         if (is_hdr) begin
            if (asm_q != ASM_HDR) begin
               frame_err_d = 1'b1;
            end
            op_d       = rx_data[6:5];
            xa_d[11:7] = rx_data[4:0];
            asm_d      = ASM_D1;
         end else begin
            case (asm_q)
               ASM_HDR: frame_err_d = 1'b1;
               ASM_D1: begin
                  xa_d[6:0] = rx_data[6:0];
                  asm_d     = ASM_D2;
               end
               ASM_D2: begin
                  yhi_d = rx_data[6:0];
                  asm_d = ASM_D3;
               end
               ASM_D3: begin
                  asm_d = ASM_HDR;
                  if (op_q[1]) begin
                     frame_err_d = 1'b1;
                  end else begin
                     pkt_done = 1'b1;
                  end
               end
               default: asm_d = ASM_HDR;
            endcase
         end
      end
   end

   // The final byte goes straight into the FIFO, so y[4:0] bypasses the
   // assembly registers.
   always_comb begin
      push_cmd.is_draw = (op_q == OP_DRAW);
      push_cmd.x       = xa_q;
      push_cmd.y       = {yhi_q, rx_data[6:2]};
   end

   assign head = cmd_t'(fifo_dout);

   // Issue FSM: GAP ignores ready for one cycle after each pulse.
   always_comb begin
      iss_d      = iss_q;
      pop        = 1'b0;
      x_d        = x_q;
      y_d        = y_q;
      draw_d     = 1'b0;
      jump_d     = 1'b0;
      case (iss_q)
         ISS_IDLE: begin
            if (!fifo_empty && ready) begin
               pop    = 1'b1;
               x_d    = head.x;
               y_d    = head.y;
               draw_d = head.is_draw;
               jump_d = !head.is_draw;
               iss_d  = ISS_GAP;
            end
         end
         ISS_GAP:  iss_d = ISS_IDLE;
         default:  iss_d = ISS_IDLE;
      endcase
      overflow_d = pkt_done && fifo_full && !pop;
   end

   cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (pkt_done),
      .pop     (pop),
      .din     (push_cmd),
      .dout    (fifo_dout),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .level   (fifo_level)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         asm_q       <= ASM_HDR;
         iss_q       <= ISS_IDLE;
         op_q        <= '0;
         xa_q        <= '0;
         yhi_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         draw_q      <= 1'b0;
         jump_q      <= 1'b0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         asm_q       <= asm_d;
         iss_q       <= iss_d;
         op_q        <= op_d;
         xa_q        <= xa_d;
         yhi_q       <= yhi_d;
         x_q         <= x_d;
         y_q         <= y_d;
         draw_q      <= draw_d;
         jump_q      <= jump_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   assign x         = x_q;
   assign y         = y_q;
   assign draw      = draw_q;
   assign jump      = jump_q;
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_vector_cmd_parser.sv
module tb_vector_cmd_parser;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        ready = 1'b0;
   logic [11:0] x, y;
   logic        draw, jump;
   logic [3:0]  fifo_level;
   logic        frame_err, overflow;

   vector_cmd_parser #(.FIFO_DEPTH(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .ready      (ready),
      .x          (x),
      .y          (y),
      .draw       (draw),
      .jump       (jump),
      .fifo_level (fifo_level),
      .frame_err  (frame_err),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        d;
      logic [11:0] px;
      logic [11:0] py;
      int unsigned c;
   } rec_t;

   rec_t        log_q[$];
   int unsigned cyc = 0;
   int unsigned fe_cnt = 0;
   int unsigned ov_cnt = 0;
   bit          both_seen = 1'b0;
   int          n_vec = 0;
   int          n_err = 0;

   always @(negedge clk) begin
      if (reset_n) begin
         cyc++;
         if (draw || jump) log_q.push_back('{d: draw, px: x, py: y, c: cyc});
         if (draw && jump) both_seen = 1'b1;
         if (frame_err) fe_cnt++;
         if (overflow) ov_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_pkt(input logic [1:0] op, input logic [11:0] px, input logic [11:0] py);
      send_byte({1'b1, op, px[11:7]});
      send_byte({1'b0, px[6:0]});
      send_byte({1'b0, py[11:5]});
      send_byte({1'b0, py[4:0], 2'b00});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_x"}, 32'(x), 32'h0);
      chk({tag, "_y"}, 32'(y), 32'h0);
      chk({tag, "_draw"}, 32'(draw), 32'h0);
      chk({tag, "_jump"}, 32'(jump), 32'h0);
      chk({tag, "_level"}, 32'(fifo_level), 32'h0);
      chk({tag, "_ferr"}, 32'(frame_err), 32'h0);
      chk({tag, "_ovf"}, 32'(overflow), 32'h0);
   endtask

   logic [11:0] ex_x [9];
   logic [11:0] ex_y [9];
   logic        ex_d [9];
   int unsigned fe0, ov0;

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clk);

      // Single DRAW: A0 1E 00 0C -> (0x01E, 0x003)
      ready = 1'b1;
      log_q.delete();
      send_byte(8'hA0); send_byte(8'h1E); send_byte(8'h00); send_byte(8'h0C);
      chk("draw_lvl_n1", 32'(fifo_level), 32'd1);
      chk("draw_early", 32'(draw), 32'h0);
      @(negedge clk);
      chk("draw_pulse", 32'(draw), 32'h1);
      chk("draw_nojump", 32'(jump), 32'h0);
      chk("draw_x", 32'(x), 32'h01E);
      chk("draw_y", 32'(y), 32'h003);
      chk("draw_lvl_n2", 32'(fifo_level), 32'd0);
      @(negedge clk);
      chk("draw_1cyc", 32'(draw), 32'h0);
      chk("draw_xhold", 32'(x), 32'h01E);
      repeat (3) @(negedge clk);
      #1;
      chk("draw_count", 32'(log_q.size()), 32'd1);

      // Single JUMP: 9F 7F 40 00 -> (0xFFF, 0x800)
      send_byte(8'h9F); send_byte(8'h7F); send_byte(8'h40); send_byte(8'h00);
      @(negedge clk);
      chk("jump_pulse", 32'(jump), 32'h1);
      chk("jump_nodraw", 32'(draw), 32'h0);
      chk("jump_x", 32'(x), 32'hFFF);
      chk("jump_y", 32'(y), 32'h800);
      @(negedge clk);
      chk("jump_1cyc", 32'(jump), 32'h0);

      // Resync: header mid-packet aborts and restarts
      repeat (2) @(negedge clk);
      #1;
      fe0 = fe_cnt;
      log_q.delete();
      send_byte(8'hA0); send_byte(8'h1E); send_byte(8'h9F);
      chk("resync_ferr", 32'(frame_err), 32'h1);
      send_byte(8'h7F); send_byte(8'h40); send_byte(8'h00);
      repeat (4) @(negedge clk);
      #1;
      chk("resync_ferr_cnt", fe_cnt - fe0, 32'd1);
      chk("resync_cmds", 32'(log_q.size()), 32'd1);
      if (log_q.size() == 1) begin
         chk("resync_isjump", 32'(log_q[0].d), 32'h0);
         chk("resync_x", 32'(log_q[0].px), 32'hFFF);
         chk("resync_y", 32'(log_q[0].py), 32'h800);
      end

      // Back-pressure and overflow
      ready = 1'b0;
      log_q.delete();
      ov0 = ov_cnt;
      fe0 = fe_cnt;
      for (int i = 0; i < 9; i++) begin
         ex_x[i] = 12'h100 + 12'(i * 17);
         ex_y[i] = 12'hA00 - 12'(i * 33);
         ex_d[i] = i[0];
         send_pkt({1'b0, ex_d[i]}, ex_x[i], ex_y[i]);
         if (i == 7) chk("bp_full_noovf", 32'(overflow), 32'h0);
      end
      chk("bp_ovf_pulse", 32'(overflow), 32'h1);
      chk("bp_level", 32'(fifo_level), 32'd8);
      ready = 1'b1;
      repeat (24) @(negedge clk);
      #1;
      chk("bp_ovf_cnt", ov_cnt - ov0, 32'd1);
      chk("bp_ferr_cnt", fe_cnt - fe0, 32'd0);
      chk("bp_drained", 32'(fifo_level), 32'd0);
      chk("bp_cmds", 32'(log_q.size()), 32'd8);
      if (log_q.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            chk($sformatf("bp_op%0d", i), 32'(log_q[i].d), 32'(ex_d[i]));
            chk($sformatf("bp_x%0d", i), 32'(log_q[i].px), 32'(ex_x[i]));
            chk($sformatf("bp_y%0d", i), 32'(log_q[i].py), 32'(ex_y[i]));
            if (i > 0) chk($sformatf("bp_gap%0d", i), 32'(log_q[i].c - log_q[i-1].c >= 2), 32'h1);
         end
      end

      // Reserved opcode then a stray data byte
      fe0 = fe_cnt;
      log_q.delete();
      send_byte(8'hC0); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      chk("rsv_ferr", 32'(frame_err), 32'h1);
      send_byte(8'h05);
      chk("stray_ferr", 32'(frame_err), 32'h1);
      repeat (4) @(negedge clk);
      #1;
      chk("rsv_ferr_cnt", fe_cnt - fe0, 32'd2);
      chk("rsv_level", 32'(fifo_level), 32'd0);
      chk("rsv_cmds", 32'(log_q.size()), 32'd0);

      // Reset mid-operation
      ready = 1'b0;
      send_pkt(2'b01, 12'h123, 12'h456);
      send_pkt(2'b00, 12'h234, 12'h567);
      send_pkt(2'b01, 12'h345, 12'h678);
      send_byte({1'b1, 2'b01, 5'h0A}); send_byte(8'h11); send_byte(8'h22);
      chk("mid_level", 32'(fifo_level), 32'd3);
      #2 reset_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      @(negedge clk);
      reset_n = 1'b1;
      ready = 1'b1;
      log_q.delete();
      fe0 = fe_cnt;
      repeat (4) @(negedge clk);
      #1;
      chk("post_rst_cmds", 32'(log_q.size()), 32'd0);
      chk("post_rst_level", 32'(fifo_level), 32'd0);
      send_pkt(2'b01, 12'h7A5, 12'h05A);
      chk("fresh_level", 32'(fifo_level), 32'd1);
      @(negedge clk);
      chk("fresh_draw", 32'(draw), 32'h1);
      chk("fresh_x", 32'(x), 32'h7A5);
      chk("fresh_y", 32'(y), 32'h05A);
      #1;
      chk("fresh_ferr_cnt", fe_cnt - fe0, 32'd0);

      chk("never_both", 32'(both_seen), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vector_cmd_parser.md
# vector_cmd_parser

Upstream feeder for the vector line-draw `control` stage. Takes received UART bytes, assembles them into 4-byte vector commands (JUMP or DRAW to a 12-bit x/y point), and buffers the commands in a small FIFO. It then issues each command to `control` as a one-cycle `draw`/`jump` pulse with x/y held, gated by `control`'s `ready`. It replaces the hard-coded shape sequencer used for bring-up, so that a host can stream vector lists over UART.

## Interface
- `FIFO_DEPTH`, default 8: command FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  received UART byte; valid only when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `ready`  in  1  from `control`; high when it can accept a command.
- `x`  out  12  target x to `control`; held between commands.
- `y`  out  12  target y to `control`; held between commands.
- `draw`  out  1  one-cycle pulse: draw a line from the current position to (x,y).
- `jump`  out  1  one-cycle pulse: move the beam to (x,y) blanked.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of queued commands.
- `frame_err`  out  1  one-cycle pulse on a byte-framing or opcode error.
- `overflow`  out  1  one-cycle pulse when a complete packet is dropped because the FIFO is full.

## Operation
- **Packet format.** Each packet is 4 bytes. A header byte has bit 7 = 1; a data byte has bit 7 = 0.
  - b0 = {1, op[1:0], x[11:7]}
  - b1 = {0, x[6:0]}
  - b2 = {0, y[11:5]}
  - b3 = {0, y[4:0], 2'b00}; b3[1:0] is ignored.
- **Opcodes.** op 00 = JUMP, 01 = DRAW. op 10 and 11 are reserved: the packet is assembled and then dropped with a `frame_err` pulse.
- **Assembler FSM.** States are HDR, D1, D2, D3; it advances only on `rx_valid`.
  - In HDR, a header byte latches op and x[11:7] and moves to D1. A data byte is discarded with `frame_err`, and the FSM stays in HDR.
  - In D1/D2/D3, a data byte stores its field and advances. A header byte aborts the partial packet (`frame_err`) and is taken as a new b0, so the next state is D1.
  - A valid data byte in D3 completes the packet and returns to HDR.
- **Push.** A completed packet with a valid op pushes {op[0], x, y} (25 bits) into the FIFO. If the FIFO is full and no pop happens in the same cycle, the packet is dropped with an `overflow` pulse. If the FIFO is full and a pop does happen that cycle, the push succeeds.
- **Issue FSM.** States are IDLE, GAP.
  - In IDLE, if the FIFO is non-empty and `ready`=1: pop the entry, register x/y, pulse `draw` (op=01) or `jump` (op=00) on the next cycle, and go to GAP.
  - GAP lasts exactly one cycle and then returns to IDLE. `ready` is ignored in GAP, which covers `control` dropping `ready` one cycle after it samples the pulse.
- **Output exclusivity.** `draw` and `jump` are never both high. Each is high for exactly one cycle per command.
- **Reset.** Asserting `reset_n` low, including mid-packet or mid-issue, asynchronously clears:
  - the assembler (to HDR), FIFO pointers, and issue FSM (to IDLE);
  - outputs `x`=0, `y`=0, `draw`=0, `jump`=0, `fifo_level`=0, `frame_err`=0, `overflow`=0.
  - Partial packets and queued commands are lost.

## Timing
- **Latency.** With b3's `rx_valid` at cycle N, the FIFO is non-empty and `fifo_level` increments at N+1. With `ready`=1 and the issue FSM in IDLE, `draw`/`jump` is high and x/y are valid at N+2.
- **Throughput.** At most one command every 2 cycles when `ready` stays high.
- **x/y stability.** x/y change only in the cycle that the pulse asserts, and stay stable until the next issue.
- **Simultaneous push and pop.** `fifo_level` is unchanged; the FIFO is first-word ordered, and a command is never issued in the same cycle it is pushed.
- **Status pulses.** `frame_err` and `overflow` are registered and pulse the cycle after the offending byte.

## Structure
- **Package `vector_cmd_pkg`.** Holds:
  - opcode constants OP_JUMP=2'b00 and OP_DRAW=2'b01;
  - COORD_W=12 and CMD_W=25;
  - the header-bit position (7).
- **Sub-module `cmd_fifo`.** A synchronous single-clock FIFO with parameters WIDTH and DEPTH; ports push/pop/din/dout/empty/full/level; async active-low reset. The top level holds both FSMs and the output registers.

## Test plan
- **Single DRAW.** Send bytes A0,1E,00,0C with `ready`=1 → one-cycle `draw` at N+2 with x=0x01E, y=0x003; `jump` stays 0 throughout.
- **Single JUMP.** Send 9F,7F,40,00 → one-cycle `jump` with x=0xFFF, y=0x800.
- **Resync.** Send A0,1E,9F,7F,40,00 → `frame_err` pulses once when 9F arrives; exactly one command is issued, a JUMP to (0xFFF,0x800).
- **Back-pressure and overflow.** Hold `ready`=0 and send 9 valid packets with FIFO_DEPTH=8 → `fifo_level`=8 and one `overflow` pulse. Then release `ready` → exactly 8 commands are issued in order, at most one every 2 cycles.
- **Reserved opcode and stray data byte.** Send C0,00,00,00, then a lone 05 → two `frame_err` pulses; `fifo_level` stays 0 and no pulses are issued.
- **Reset mid-operation.** Drop `reset_n` after b2 of a packet while the FIFO holds 3 commands → all outputs go to 0 at once and `fifo_level`=0. After release, a fresh packet is issued normally.
